// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode is stalled.
module fetch_skid
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_instr,
  output logic             o_full,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_instr
);

  logic             r_full;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // data regs are reset too, keeping the skid outputs deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_pc    <= '0;
      r_instr <= WIDTH'(NOP_INSTR);
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and the
// IF/ID pipeline register, with decode backpressure and redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  input  logic             id_stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_id_valid,
  output logic [WIDTH-1:0] if_id_pc,
  output logic [WIDTH-1:0] if_id_instr
);

  fetch_state_e     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_req_pc;
  logic             r_if_id_valid;
  logic [WIDTH-1:0] r_if_id_pc;
  logic [WIDTH-1:0] r_if_id_instr;

  logic             w_handshake;
  logic             w_resp;
  logic             w_if_id_free;
  logic [WIDTH-1:0] w_redirect_pc;
  logic             w_skid_full;
  logic [WIDTH-1:0] w_skid_pc;
  logic [WIDTH-1:0] w_skid_instr;
  logic             w_skid_load;
  logic             w_skid_pop;

  // Request side depends only on state/pc/skid, never on redirect inputs.
  assign imem_req_valid = !rst && (r_state == FETCH) && !w_skid_full;
  assign imem_req_addr  = r_pc;

  assign w_handshake   = imem_req_valid && imem_req_ready;
  assign w_resp        = imem_resp_valid && (r_state == WAIT);
  assign w_if_id_free  = !r_if_id_valid || !id_stall;
  assign w_redirect_pc = redirect_pc & ~WIDTH'(3);

  // A response only arrives in WAIT, when the skid is known to be empty.
  assign w_skid_load = w_resp && !w_if_id_free;
  assign w_skid_pop  = w_skid_full && w_if_id_free;

  fetch_skid #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_clear (redirect_valid),
    .i_pc    (r_req_pc),
    .i_instr (imem_resp_data),
    .o_full  (w_skid_full),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= WIDTH'(NOP_INSTR);
    end else if (redirect_valid) begin
      r_if_id_valid <= 1'b0;
      r_pc          <= w_redirect_pc;
      // Any outstanding request is stale; a response arriving now retires it.
      case (r_state)
        FETCH:   r_state <= w_handshake ? DISCARD : FETCH;
        WAIT:    r_state <= imem_resp_valid ? FETCH : DISCARD;
        DISCARD: r_state <= imem_resp_valid ? FETCH : DISCARD;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_handshake) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + WIDTH'(4);
            r_state  <= WAIT;
          end
        end
        WAIT:    if (imem_resp_valid) r_state <= FETCH;
        DISCARD: if (imem_resp_valid) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase

      // The skid always drains ahead of any newer response.
      if (w_resp) begin
        if (w_if_id_free) begin
          r_if_id_valid <= 1'b1;
          r_if_id_pc    <= r_req_pc;
          r_if_id_instr <= imem_resp_data;
        end
      end else if (w_skid_pop) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= w_skid_pc;
        r_if_id_instr <= w_skid_instr;
      end else if (!id_stall) begin
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based model of the decode-visible
// instruction stream plus directed scenarios with literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_stall        (id_stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory responder: one response per accepted request, lat cycles later.
  int          lat;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  initial begin
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
          pend            = 1'b0;
        end
      end
    end
  end

  // Model: the instructions waiting for decode form a queue of at most two;
  // the head is what IF/ID shows. One fetch may be outstanding, possibly stale.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_last;
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_out_addr;

  task automatic m_reset();
    m_q.delete();
    m_pc    = 32'h100;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_last  = '{pc: 32'h0, instr: 32'h13};
  endtask

  initial begin
    logic exp_rv;
    logic hs;
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      exp_rv = !rst && !m_out && (m_q.size() < 2);
      check("m_req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("m_req_addr", imem_req_addr, m_pc);
      check("m_if_id_valid", 32'(if_id_valid), 32'(m_q.size() > 0));
      check("m_if_id_pc", if_id_pc, m_last.pc);
      check("m_if_id_instr", if_id_instr, m_last.instr);
      if (!rst) begin
        if (imem_req_valid && imem_req_ready) begin
          pend      = 1'b1;
          pend_addr = imem_req_addr;
          pend_cnt  = lat;
        end
        hs = exp_rv && imem_req_ready;
        if (redirect_valid) begin
          m_q.delete();
          m_pc = redirect_pc & ~32'd3;
          if (m_out && imem_resp_valid) m_out = 1'b0;
          if (hs) begin
            m_out   = 1'b1;
            m_stale = 1'b1;
          end else if (m_out) begin
            m_stale = 1'b1;
          end
        end else begin
          if (m_q.size() > 0 && !id_stall) void'(m_q.pop_front());
          if (m_out && imem_resp_valid) begin
            if (!m_stale) m_q.push_back('{pc: m_out_addr, instr: mem_word(m_out_addr)});
            m_out = 1'b0;
          end
          if (hs) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_out_addr = m_pc;
            m_pc       = m_pc + 32'd4;
          end
        end
        if (m_q.size() > 0) m_last = m_q[0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_ifid(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, 32'(if_id_valid), 32'(v));
    if (v) begin
      check({name, "_pc"}, if_id_pc, pc);
      check({name, "_instr"}, if_id_instr, mem_word(pc));
    end
  endtask

  logic [47:0] rdy_pat;
  logic [47:0] st_pat;
  logic [47:0] rd_pat;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    step(); step();
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_if_id_instr", if_id_instr, 32'h0000_0013);
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
    check("post_rst_addr", imem_req_addr, 32'h100);
    check("post_rst_if_id_valid", 32'(if_id_valid), 32'h0);
    check("post_rst_if_id_pc", if_id_pc, 32'h0);

    // Memory not ready: request held, pc frozen
    repeat (3) begin
      step();
      check("not_ready_valid", 32'(imem_req_valid), 32'h1);
      check("not_ready_addr", imem_req_addr, 32'h100);
    end
    imem_req_ready = 1'b1;
    step();
    check("wait_no_req", 32'(imem_req_valid), 32'h0);
    step();
    check_ifid("first_instr", 1'b1, 32'h100);
    check("first_next_addr", imem_req_addr, 32'h104);

    // Decode stall: 0x104 parks in the skid, no new request
    id_stall = 1'b1;
    step();
    check_ifid("stall_hold", 1'b1, 32'h100);
    check("stall_wait_req", 32'(imem_req_valid), 32'h0);
    step();
    check_ifid("skid_loaded_hold", 1'b1, 32'h100);
    check("skid_full_no_req", 32'(imem_req_valid), 32'h0);
    step();
    check("skid_full_no_req2", 32'(imem_req_valid), 32'h0);
    id_stall = 1'b0;
    step();
    check_ifid("skid_drain", 1'b1, 32'h104);
    check("after_drain_req", 32'(imem_req_valid), 32'h1);
    check("after_drain_addr", imem_req_addr, 32'h108);

    // Redirect while waiting on a slow response
    lat = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0; lat = 1;
    check("discard_if_id_valid", 32'(if_id_valid), 32'h0);
    check("discard_no_req", 32'(imem_req_valid), 32'h0);
    step();
    check("discard_still_no_req", 32'(imem_req_valid), 32'h0);
    step();
    check("redir_req_valid", 32'(imem_req_valid), 32'h1);
    check("redir_addr", imem_req_addr, 32'h200);
    check("redir_stale_dropped", 32'(if_id_valid), 32'h0);
    step(); step();
    check_ifid("redir_target_instr", 1'b1, 32'h200);
    check("redir_next_addr", imem_req_addr, 32'h204);

    // Redirect coincident with a handshake
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    check("hs_redir_no_req", 32'(imem_req_valid), 32'h0);
    check("hs_redir_flush", 32'(if_id_valid), 32'h0);
    step();
    check("hs_redir_req", 32'(imem_req_valid), 32'h1);
    check("hs_redir_addr", imem_req_addr, 32'h300);
    check("hs_redir_dropped", 32'(if_id_valid), 32'h0);
    step(); step();
    check_ifid("hs_redir_target", 1'b1, 32'h300);

    // Redirect with decode stalled and the skid full
    id_stall = 1'b1;
    step(); step();
    check("full_skid_no_req", 32'(imem_req_valid), 32'h0);
    check_ifid("full_skid_hold", 1'b1, 32'h300);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    check("skid_redir_flush", 32'(if_id_valid), 32'h0);
    check("skid_redir_req", 32'(imem_req_valid), 32'h1);
    check("skid_redir_addr", imem_req_addr, 32'h400);
    id_stall = 1'b0;
    step(); step();
    check_ifid("skid_redir_target", 1'b1, 32'h400);

    // Asynchronous reset in the middle of WAIT
    lat = 3;
    step();
    #1 rst = 1'b1;
    #1;
    check("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("async_rst_if_id_valid", 32'(if_id_valid), 32'h0);
    check("async_rst_if_id_pc", if_id_pc, 32'h0);
    check("async_rst_if_id_instr", if_id_instr, 32'h0000_0013);
    step(); step();
    rst = 1'b0; lat = 1;
    #1;
    check("rerst_req_valid", 32'(imem_req_valid), 32'h1);
    check("rerst_addr", imem_req_addr, 32'h100);

    // Mixed traffic, checked by the model every cycle
    rdy_pat = 48'hF7DF_BEFB_7FFF;
    st_pat  = 48'h0C30_6180_E1C3;
    rd_pat  = 48'h0002_0000_8040;
    for (int i = 0; i < 48; i++) begin
      imem_req_ready = rdy_pat[i];
      id_stall       = st_pat[i];
      redirect_valid = rd_pat[i];
      redirect_pc    = 32'h500 + 32'(i * 8) + 32'd1;
      lat            = 1 + (i % 3);
      step();
    end
    imem_req_ready = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; lat = 1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
